// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Reserved size yields zero bytes; callers reject it separately.
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [31:0] data, input logic [1:0] size);
    case (size)
      SZ_BYTE: return {24'h0, data[7:0]};
      SZ_HALF: return {16'h0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the port not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (LSU / debug-DMA) data-memory arbiter, one access per three cycles.
// Optional alignment rejection is enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DROM_SPACE = 1024,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [1:0]        p0_size,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [1:0]        p1_size,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [31:0]       data_addr,
  output logic [31:0]       w_data_mem,
  output logic              r_en_mem,
  output logic              w_en_mem,
  output logic [1:0]        byte_sel,
  input  logic [31:0]       r_data_mem
);

  localparam logic [ADDR_W:0] DROM_LIM = (ADDR_W+1)'(DROM_SPACE);

  state_t state, state_nxt;

  logic              last_q;
  logic              win_q;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [1:0]        lat_size;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic [1:0]        pick;
  logic [ADDR_W:0]   end_addr;
  logic              misalign;
  logic              reject;

  rr_arb2 u_rr (
    .req  ({p1_req, p0_req}),
    .last (last_q),
    .gnt  (pick)
  );

  // One extra bit so addresses near the top of ADDR_W cannot wrap past the limit.
  assign end_addr = {1'b0, lat_addr} + (ADDR_W+1)'(access_bytes(lat_size));

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign = (lat_size == SZ_HALF && lat_addr[0]) ||
                    (lat_size == SZ_WORD && lat_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign reject = (lat_size == SZ_RSVD) || (end_addr > DROM_LIM) || misalign;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick != 2'b00) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last_q = 1 after reset so that port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= SZ_BYTE;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (state == IDLE && pick != 2'b00) begin
        win_q     <= pick[1];
        lat_we    <= pick[1] ? p1_we    : p0_we;
        lat_addr  <= pick[1] ? p1_addr  : p0_addr;
        lat_wdata <= pick[1] ? p1_wdata : p0_wdata;
        lat_size  <= pick[1] ? p1_size  : p0_size;
      end
      if (state == ACCESS) begin
        resp_err  <= reject;
        resp_data <= (reject || lat_we) ? 32'h0 : size_mask(r_data_mem, lat_size);
      end
      if (state == RESP) last_q <= win_q;
    end
  end

  // Outputs are gated by rst so an access caught by reset never reaches memory.
  always_comb begin
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    p0_rvalid  = 1'b0;
    p1_rvalid  = 1'b0;
    p0_rdata   = 32'h0;
    p1_rdata   = 32'h0;
    p0_err     = 1'b0;
    p1_err     = 1'b0;
    r_en_mem   = 1'b0;
    w_en_mem   = 1'b0;
    data_addr  = 32'h0;
    w_data_mem = 32'h0;
    byte_sel   = 2'b00;
    if (!rst) begin
      case (state)
        ACCESS: begin
          p0_gnt = !win_q;
          p1_gnt = win_q;
          if (!reject) begin
            r_en_mem   = !lat_we;
            w_en_mem   = lat_we;
            data_addr  = 32'(lat_addr);
            w_data_mem = lat_wdata;
            byte_sel   = lat_size;
          end
        end
        RESP: begin
          p0_rvalid = !win_q;
          p1_rvalid = win_q;
          if (win_q) begin
            p1_rdata = resp_data;
            p1_err   = resp_err;
          end else begin
            p0_rdata = resp_data;
            p0_err   = resp_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random single-port traffic.
module tb_dmem_arbiter;

  localparam int DS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_mem;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [1:0]  p0_size, p1_size;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] data_addr, w_data_mem, r_data_mem;
  logic        r_en_mem, w_en_mem;
  logic [1:0]  byte_sel;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem     [DS];
  logic [7:0] ref_mem [DS];

  always #5 clk = ~clk;

  dmem_arbiter #(.DROM_SPACE(DS), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .data_addr(data_addr), .w_data_mem(w_data_mem), .r_en_mem(r_en_mem),
    .w_en_mem(w_en_mem), .byte_sel(byte_sel), .r_data_mem(r_data_mem)
  );

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  // Memory model: little-endian byte array, combinational 4-byte read from data_addr.
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    if (a < DS) return mem[a[9:0]];
    return 8'h00;
  endfunction

  assign r_data_mem = {mbyte(data_addr + 32'd3), mbyte(data_addr + 32'd2),
                       mbyte(data_addr + 32'd1), mbyte(data_addr)};

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DS; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (w_en_mem) begin
      for (int i = 0; i < 4; i++)
        if (i < nbytes(byte_sel) && (data_addr + 32'(i)) < DS)
          mem[data_addr[9:0] + 10'(i)] <= w_data_mem[8*i +: 8];
    end
  end

  // Reference rules: reject reserved size, range overrun and (optionally) misalignment.
  function automatic bit exp_err(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b11) return 1'b1;
    if (longint'(a) + longint'(nbytes(sz)) > longint'(DS)) return 1'b1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if (sz == 2'b01 && a[0]) return 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = ref_mem[a[9:0] + 10'(i)];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_size = sz;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_size = sz;
    end
  endtask

  // One complete transaction from an idle arbiter; returns at the RESP negedge.
  task automatic access(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz);
    bit          e;
    bit          got;
    int          waited;
    logic [31:0] rexp;
    e    = exp_err(addr, sz);
    rexp = (e || we) ? 32'h0 : exp_read(addr, sz);
    @(posedge clk); #1;
    drive(port, 1'b1, we, addr, wd, sz);
    got = 1'b0;
    waited = 0;
    while (!got && waited < 6) begin
      @(negedge clk);
      waited++;
      got = (port == 0) ? p0_gnt : p1_gnt;
    end
    if (!got) begin
      chk("gnt_timeout", 32'(got), 32'd1);
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      return;
    end
    chk("gnt_latency", 32'(waited), 32'd2);
    chk("other_gnt", 32'((port == 0) ? p1_gnt : p0_gnt), 32'd0);
    chk("w_en_mem", 32'(w_en_mem), 32'(!e && we));
    chk("r_en_mem", 32'(r_en_mem), 32'(!e && !we));
    chk("data_addr", data_addr, e ? 32'h0 : addr);
    chk("byte_sel", 32'(byte_sel), e ? 32'h0 : 32'(sz));
    if (we && !e) chk("w_data_mem", w_data_mem, wd);
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    chk("rvalid", 32'((port == 0) ? p0_rvalid : p1_rvalid), 32'd1);
    chk("other_rvalid", 32'((port == 0) ? p1_rvalid : p0_rvalid), 32'd0);
    chk("err", 32'((port == 0) ? p0_err : p1_err), 32'(e));
    if (!we || e) chk("rdata", (port == 0) ? p0_rdata : p1_rdata, rexp);
    chk("en_in_resp", 32'({r_en_mem, w_en_mem}), 32'd0);
    if (we && !e)
      for (int i = 0; i < nbytes(sz); i++) ref_mem[addr[9:0] + 10'(i)] = wd[8*i +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ng, t;
    int          port;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;

    for (int i = 0; i < DS; i++) ref_mem[i] = 8'(i * 7 + 3);
    rst = 1'b1;
    init_mem = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b10);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
    chk("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
    chk("rst_err_rdata", p0_rdata | p1_rdata | 32'({p1_err, p0_err}), 32'd0);
    chk("rst_mem_en", 32'({r_en_mem, w_en_mem, byte_sel}), 32'd0);
    chk("rst_mem_bus", data_addr | w_data_mem, 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    init_mem = 1'b0;

    // Word write then read-back, byte extraction from a stored word.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10);
    access(0, 1'b0, 32'h10, 32'h0, 2'b10);
    access(0, 1'b1, 32'h10, 32'hAABBCCDD, 2'b10);
    access(1, 1'b0, 32'h11, 32'h0, 2'b00);
    chk("byte_read_literal", exp_read(32'h11, 2'b00), 32'h000000CC);

    // Range boundaries, reserved size and a misaligned half write.
    access(0, 1'b0, 32'd1022, 32'h0, 2'b10);
    access(0, 1'b0, 32'd1020, 32'h0, 2'b10);
    access(1, 1'b0, 32'd1023, 32'h0, 2'b00);
    access(1, 1'b0, 32'd1023, 32'h0, 2'b01);
    access(0, 1'b0, 32'h20, 32'h0, 2'b11);
    access(0, 1'b1, 32'h21, 32'h00001234, 2'b01);
    access(1, 1'b0, 32'h20, 32'h0, 2'b10);

    // Both ports held from reset: grants alternate p0, p1, ... every 3 cycles.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
    drive(1, 1'b1, 1'b0, 32'h44, 32'h0, 2'b10);
    ng = 0;
    t = 0;
    while (ng < 4 && t < 16) begin
      @(negedge clk);
      t++;
      if (p0_gnt || p1_gnt) begin
        chk("rr_time", 32'(t), 32'(2 + 3 * ng));
        chk("rr_port", 32'({p1_gnt, p0_gnt}), (ng % 2 == 1) ? 32'd2 : 32'd1);
        ng++;
      end
    end
    if (ng < 4) chk("rr_timeout", 32'(ng), 32'd4);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    repeat (2) @(negedge clk);

    // Last completion on p0 so only a pointer reset lets p0 win after rst.
    access(0, 1'b0, 32'h80, 32'h0, 2'b10);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 32'h80, 32'h55AA55AA, 2'b10);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    chk("abort_w_en", 32'(w_en_mem), 32'd0);
    chk("abort_gnt", 32'(p1_gnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h84, 32'h0, 2'b10);
    drive(1, 1'b1, 1'b0, 32'h88, 32'h0, 2'b10);
    @(negedge clk);
    chk("abort_no_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
    @(negedge clk);
    chk("post_rst_first_gnt", 32'({p1_gnt, p0_gnt}), 32'd1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    chk("post_rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd1);
    @(negedge clk);
    access(1, 1'b0, 32'h80, 32'h0, 2'b10);

    // Random single-port traffic against the reference model.
    for (int k = 0; k < 60; k++) begin
      port = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0, 1:    addr = 32'($urandom_range(0, 63));
        2:       addr = 32'($urandom_range(1016, 1023));
        default: addr = 32'($urandom_range(1020, 1100));
      endcase
      access(port, we, addr, $urandom, sz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
